// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard-unit types: scoreboard slot layout and decode forwarding-mux select codes.
package hazard_ctrl_pkg;

  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0, is_load: 1'b0};

  // A load sitting in MEM has no value yet, so it must not win the MEM path.
  function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic mem_is_load,
                                          input logic wb_hit);
    if (mem_hit && !mem_is_load) return FWD_MEM;
    if (wb_hit) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// Compares one scoreboard slot against the decode operands; $0 and empty slots never match.
module hazard_slot_match
  import hazard_ctrl_pkg::*;
(
  input  logic       slot_valid,
  input  logic [4:0] slot_rd,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       use_rs,
  input  logic       use_rt,
  output logic       match_rs,
  output logic       match_rt
);

  logic live;

  assign live     = slot_valid && (slot_rd != 5'd0);
  assign match_rs = live && use_rs && (slot_rd == rs);
  assign match_rt = live && use_rt && (slot_rd == rt);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard unit: EX/MEM/WB write scoreboard, stall/forward generation, divider busy.
// Optional HAZARD_PERF_EN adds a free-running stall-cycle counter on stall_cnt.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_useRs,
  input  logic        ID_useRt,
  input  logic        ID_cmp,
  input  logic        ID_RegWrite,
  input  logic        ID_Mem2Reg,
  input  logic [4:0]  ID_Rd,
  input  logic        ID_divStart,
  input  logic        ID_useHiLo,
  input  logic        EX_MEM_branch_tacken,
  output logic        stall,
  output logic [3:0]  forwardSignal,
  output logic        div_busy,
  output logic [31:0] stall_cnt
);

  slot_t                ex_slot;
  slot_t                mem_slot;
  logic                 wb_valid;
  logic [4:0]           wb_rd;
  logic [DIV_CNT_W-1:0] div_cnt;

  logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  logic ex_hit, mem_hit;
  logic load_use, cmp_ex, cmp_load, div_wait;
  fwd_sel_e fwd_rs, fwd_rt;

  hazard_slot_match u_ex_match (
    .slot_valid (ex_slot.valid),
    .slot_rd    (ex_slot.rd),
    .rs         (ID_Rs),
    .rt         (ID_Rt),
    .use_rs     (ID_useRs),
    .use_rt     (ID_useRt),
    .match_rs   (ex_rs),
    .match_rt   (ex_rt)
  );

  hazard_slot_match u_mem_match (
    .slot_valid (mem_slot.valid),
    .slot_rd    (mem_slot.rd),
    .rs         (ID_Rs),
    .rt         (ID_Rt),
    .use_rs     (ID_useRs),
    .use_rt     (ID_useRt),
    .match_rs   (mem_rs),
    .match_rt   (mem_rt)
  );

  hazard_slot_match u_wb_match (
    .slot_valid (wb_valid),
    .slot_rd    (wb_rd),
    .rs         (ID_Rs),
    .rt         (ID_Rt),
    .use_rs     (ID_useRs),
    .use_rt     (ID_useRt),
    .match_rs   (wb_rs),
    .match_rt   (wb_rt)
  );

  assign ex_hit   = ex_rs || ex_rt;
  assign mem_hit  = mem_rs || mem_rt;
  assign div_busy = (div_cnt != '0);

  assign load_use = ex_slot.is_load && ex_hit;
  assign cmp_ex   = ID_cmp && ex_hit;
  assign cmp_load = ID_cmp && mem_slot.is_load && mem_hit;
  assign div_wait = (ID_divStart || ID_useHiLo) && div_busy;

  // A taken branch squashes the decode slot, so nothing there is worth waiting for.
  assign stall = !EX_MEM_branch_tacken && (load_use || cmp_ex || cmp_load || div_wait);

  assign fwd_rs        = fwd_select(mem_rs, mem_slot.is_load, wb_rs);
  assign fwd_rt        = fwd_select(mem_rt, mem_slot.is_load, wb_rt);
  assign forwardSignal = {fwd_rs, fwd_rt};

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot  <= SLOT_EMPTY;
      mem_slot <= SLOT_EMPTY;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      div_cnt  <= '0;
    end else begin
      wb_valid <= mem_slot.valid;
      wb_rd    <= mem_slot.rd;
      mem_slot <= ex_slot;
      if (stall || EX_MEM_branch_tacken)
        ex_slot <= SLOT_EMPTY;
      else
        ex_slot <= '{valid: ID_RegWrite, rd: ID_Rd, is_load: ID_Mem2Reg};
      // Stall already blocks a second div while busy, so no restart case here.
      if (ID_divStart && !stall && !EX_MEM_branch_tacken)
        div_cnt <= DIV_CNT_W'(DIV_CYCLES);
      else if (div_busy)
        div_cnt <= div_cnt - 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      perf_cnt <= 32'd0;
    else if (stall)
      perf_cnt <= perf_cnt + 32'd1;
  end

  assign stall_cnt = perf_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus randomized traffic
// compared every cycle against an instruction-history model.
module tb_hazard_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic        ID_useRs, ID_useRt, ID_cmp, ID_RegWrite, ID_Mem2Reg;
  logic        ID_divStart, ID_useHiLo, EX_MEM_branch_tacken;
  logic        stall, div_busy;
  logic [3:0]  forwardSignal;
  logic [31:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.DIV_CYCLES(DIV)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ID_Rs                (ID_Rs),
    .ID_Rt                (ID_Rt),
    .ID_useRs             (ID_useRs),
    .ID_useRt             (ID_useRt),
    .ID_cmp               (ID_cmp),
    .ID_RegWrite          (ID_RegWrite),
    .ID_Mem2Reg           (ID_Mem2Reg),
    .ID_Rd                (ID_Rd),
    .ID_divStart          (ID_divStart),
    .ID_useHiLo           (ID_useHiLo),
    .EX_MEM_branch_tacken (EX_MEM_branch_tacken),
    .stall                (stall),
    .forwardSignal        (forwardSignal),
    .div_busy             (div_busy),
    .stall_cnt            (stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: the last three instructions that left decode (youngest first), plus divide issue time.
  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       load;
  } ent_t;

  ent_t        hist[$];
  ent_t        none_e = '{valid: 1'b0, rd: 5'd0, load: 1'b0};
  int          cyc = 0;
  int          div_issue = -100;
  int unsigned m_perf = 0;
  bit          model_ready = 1'b0;

  function automatic bit reads(ent_t e, logic [4:0] r, logic u);
    return e.valid && (e.rd != 5'd0) && u && (e.rd == r);
  endfunction

  function automatic bit reads_any(ent_t e);
    return reads(e, ID_Rs, ID_useRs) || reads(e, ID_Rt, ID_useRt);
  endfunction

  function automatic bit m_busy();
    return (cyc > div_issue) && (cyc <= div_issue + DIV);
  endfunction

  function automatic bit m_stall();
    bit need;
    need = (hist[0].load && reads_any(hist[0]))
        || (ID_cmp && reads_any(hist[0]))
        || (ID_cmp && hist[1].load && reads_any(hist[1]))
        || ((ID_divStart || ID_useHiLo) && m_busy());
    return need && !EX_MEM_branch_tacken;
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] r, logic u);
    if (reads(hist[1], r, u) && !hist[1].load) return 2'b01;
    if (reads(hist[2], r, u)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_cnt();
`ifdef HAZARD_PERF_EN
    return m_perf;
`else
    return 32'd0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hist        = '{none_e, none_e, none_e};
      div_issue   = -100;
      m_perf      = 0;
      model_ready = 1'b1;
    end else if (model_ready) begin
      bit s;
      ent_t n;
      s = m_stall();
      if (ID_divStart && !s && !EX_MEM_branch_tacken) div_issue = cyc;
      if (s) m_perf++;
      n = (s || EX_MEM_branch_tacken) ? none_e
          : '{valid: ID_RegWrite, rd: ID_Rd, load: ID_Mem2Reg};
      hist.push_front(n);
      void'(hist.pop_back());
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("model_stall", {31'd0, stall}, {31'd0, m_stall()});
      checkOutput("model_fwd", {28'd0, forwardSignal},
                  {28'd0, m_fwd(ID_Rs, ID_useRs), m_fwd(ID_Rt, ID_useRt)});
      checkOutput("model_div_busy", {31'd0, div_busy}, {31'd0, m_busy()});
      checkOutput("model_stall_cnt", stall_cnt, m_cnt());
    end
  end

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic use_rs,
                               input logic use_rt, input logic cmp, input logic reg_write,
                               input logic mem2reg, input logic [4:0] rd, input logic div_start,
                               input logic use_hilo, input logic branch);
    ID_Rs                = rs;
    ID_Rt                = rt;
    ID_useRs             = use_rs;
    ID_useRt             = use_rt;
    ID_cmp               = cmp;
    ID_RegWrite          = reg_write;
    ID_Mem2Reg           = mem2reg;
    ID_Rd                = rd;
    ID_divStart          = div_start;
    ID_useHiLo           = use_hilo;
    EX_MEM_branch_tacken = branch;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    checkOutput("reset_fwd", {28'd0, forwardSignal}, 32'd0);
    checkOutput("reset_busy", {31'd0, div_busy}, 32'd0);
    checkOutput("reset_cnt", stall_cnt, 32'd0);

    // lw $2 ; add $3,$2,$4
    applyStimulus(5'd1, 5'd0, 1, 0, 0, 1, 1, 5'd2, 0, 0, 0);
    step();
    applyStimulus(5'd2, 5'd4, 1, 1, 0, 1, 0, 5'd3, 0, 0, 0);
    checkOutput("lw_use_stall", {31'd0, stall}, 32'd1);
    step();
    checkOutput("lw_use_release", {31'd0, stall}, 32'd0);
    checkOutput("lw_in_mem_fwd", {28'd0, forwardSignal}, 32'd0);
    step();
    applyStimulus(5'd2, 5'd0, 1, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    checkOutput("lw_in_wb_fwd", {28'd0, forwardSignal}, 32'h8);
    idle(3);

    // add $5 ; beq $5,$6
    applyStimulus(5'd1, 5'd2, 1, 1, 0, 1, 0, 5'd5, 0, 0, 0);
    step();
    applyStimulus(5'd5, 5'd6, 1, 1, 1, 0, 0, 5'd0, 0, 0, 0);
    checkOutput("cmp_ex_stall", {31'd0, stall}, 32'd1);
    step();
    checkOutput("cmp_ex_release", {31'd0, stall}, 32'd0);
    checkOutput("cmp_mem_fwd", {28'd0, forwardSignal}, 32'h4);
    idle(3);

    // lw $5 ; beq $5,$6
    applyStimulus(5'd1, 5'd0, 1, 0, 0, 1, 1, 5'd5, 0, 0, 0);
    step();
    applyStimulus(5'd5, 5'd6, 1, 1, 1, 0, 0, 5'd0, 0, 0, 0);
    checkOutput("cmp_lw_stall1", {31'd0, stall}, 32'd1);
    step();
    checkOutput("cmp_lw_stall2", {31'd0, stall}, 32'd1);
    step();
    checkOutput("cmp_lw_release", {31'd0, stall}, 32'd0);
    checkOutput("cmp_lw_wb_fwd", {28'd0, forwardSignal}, 32'h8);
    idle(3);

    // add $0 ; beq $0,$0
    applyStimulus(5'd1, 5'd2, 1, 1, 0, 1, 0, 5'd0, 0, 0, 0);
    step();
    applyStimulus(5'd0, 5'd0, 1, 1, 1, 0, 0, 5'd0, 0, 0, 0);
    checkOutput("r0_stall", {31'd0, stall}, 32'd0);
    checkOutput("r0_fwd", {28'd0, forwardSignal}, 32'd0);
    idle(3);

    // div ; mflo
    applyStimulus(5'd1, 5'd2, 1, 1, 0, 0, 0, 5'd0, 1, 0, 0);
    step();
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd8, 0, 1, 0);
    for (int i = 0; i < DIV; i++) begin
      checkOutput("div_mflo_stall", {31'd0, stall}, 32'd1);
      checkOutput("div_busy_high", {31'd0, div_busy}, 32'd1);
      step();
    end
    checkOutput("div_mflo_release", {31'd0, stall}, 32'd0);
    checkOutput("div_busy_low", {31'd0, div_busy}, 32'd0);
    idle(3);

    // load hazard squashed by a taken branch
    applyStimulus(5'd1, 5'd0, 1, 0, 0, 1, 1, 5'd7, 0, 0, 0);
    step();
    applyStimulus(5'd7, 5'd0, 1, 0, 0, 1, 0, 5'd3, 0, 0, 1);
    checkOutput("branch_kills_stall", {31'd0, stall}, 32'd0);
    step();
    applyStimulus(5'd3, 5'd0, 1, 0, 1, 0, 0, 5'd0, 0, 0, 0);
    checkOutput("squashed_ex_empty", {31'd0, stall}, 32'd0);
    idle(3);

    // stall counter: three load-use stalls after a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd1, 5'd0, 1, 0, 0, 1, 1, 5'd10, 0, 0, 0);
      step();
      applyStimulus(5'd10, 5'd0, 1, 0, 0, 0, 0, 5'd0, 0, 0, 0);
      step();
      idle(2);
    end
`ifdef HAZARD_PERF_EN
    checkOutput("perf_three", stall_cnt, 32'd3);
`else
    checkOutput("perf_tied_zero", stall_cnt, 32'd0);
`endif

    // reset in the middle of a divide
    applyStimulus(5'd1, 5'd2, 1, 1, 0, 0, 0, 5'd0, 1, 0, 0);
    step();
    idle(0);
    checkOutput("mid_div_busy", {31'd0, div_busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkOutput("mid_div_reset_busy", {31'd0, div_busy}, 32'd0);
    checkOutput("mid_div_reset_cnt", stall_cnt, 32'd0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 9) == 0));
      step();
    end
    rst = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
